// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_arb_pkg
//  Description : Shared types for the FIFO write-port arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_arb_pkg;

    localparam int c_ARB_STATE_W = 1;

    typedef enum logic [c_ARB_STATE_W-1:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

endpackage : fifo_arb_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin picker; first set request at or
//                above ptr, wrapping at N-1.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter  int N       = 4,
    localparam int c_IDX_W = $clog2(N)
) (
    input  logic [N-1:0]       req,
    input  logic [c_IDX_W-1:0] ptr,
    output logic               any,
    output logic [c_IDX_W-1:0] idx
);

    // One extra bit holds ptr+k (at most 2N-2) before the explicit wrap.
    logic [c_IDX_W:0] w_pos;

    always_comb begin
        any   = 1'b0;
        idx   = '0;
        w_pos = '0;
        for (int k = 0; k < N; k++) begin
            w_pos = {1'b0, ptr} + (c_IDX_W+1)'(k);
            if (w_pos >= (c_IDX_W+1)'(N)) begin
                w_pos = w_pos - (c_IDX_W+1)'(N);
            end
            if (!any && req[w_pos[c_IDX_W-1:0]]) begin
                any = 1'b1;
                idx = w_pos[c_IDX_W-1:0];
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_wr_arbiter
//  Description : Round-robin, burst-bounded arbiter sharing one FIFO write
//                port among NUM_REQ requesters; tags each beat with its source.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int NUM_REQ   = 4,
    parameter  int WIDTH     = 8,
    parameter  int MAX_BURST = 4,
    localparam int c_IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       i_valid,
    input  logic [NUM_REQ*WIDTH-1:0] i_data,
    output logic [NUM_REQ-1:0]       o_ready,
    output logic                     o_wr_en,
    output logic [WIDTH-1:0]         o_wr_data,
    output logic [c_IDX_W-1:0]       o_wr_src,
    input  logic                     i_full,
    output logic                     o_busy
);

    localparam int                 c_CNT_W     = $clog2(MAX_BURST + 1);
    localparam logic [c_CNT_W-1:0] c_LAST_BEAT = c_CNT_W'(MAX_BURST - 1);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX  = c_IDX_W'(NUM_REQ - 1);

    arb_state_e         r_state;
    arb_state_e         w_state_nxt;
    logic [c_IDX_W-1:0] r_grant;
    logic [c_IDX_W-1:0] w_grant_nxt;
    logic [c_IDX_W-1:0] r_ptr;
    logic [c_IDX_W-1:0] w_ptr_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               w_any;
    logic [c_IDX_W-1:0] w_pick;
    logic               w_beat;
    logic               w_burst_end;

    rr_pick #(
        .N   (NUM_REQ)
    ) u_rr_pick (
        .req (i_valid),
        .ptr (r_ptr),
        .any (w_any),
        .idx (w_pick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_cnt   <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_cnt_nxt   = r_cnt;
        w_ptr_nxt   = r_ptr;
        w_beat      = 1'b0;
        w_burst_end = 1'b0;
        o_ready     = '0;
        o_wr_en     = 1'b0;
        o_wr_data   = '0;
        o_wr_src    = '0;
        o_busy      = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt = BURST;
                    w_grant_nxt = w_pick;
                    w_cnt_nxt   = '0;
                end
            end

            BURST: begin
                o_busy           = 1'b1;
                o_wr_src         = r_grant;
                o_wr_data        = i_data[r_grant*WIDTH +: WIDTH];
                // Reset suppresses any handshake so an abandoned burst loses no data.
                o_ready[r_grant] = !i_full && !rst;
                w_beat           = i_valid[r_grant] && !i_full && !rst;
                o_wr_en          = w_beat;

                // Back-pressure holds the burst; only an idle requester ends it early.
                if (w_beat) begin
                    if (r_cnt == c_LAST_BEAT) begin
                        w_burst_end = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end else if (!i_valid[r_grant] && !i_full) begin
                    w_burst_end = 1'b1;
                end

                if (w_burst_end) begin
                    w_state_nxt = IDLE;
                    w_ptr_nxt   = (r_grant == c_LAST_IDX) ? '0 : r_grant + 1'b1;
                end
            end

            default: w_state_nxt = IDLE;
        endcase
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            a_no_write_when_full: assert (!(o_wr_en && i_full));
        end
    end
`endif

endmodule : fifo_wr_arbiter
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_wr_arbiter
//  Description : Directed self-checking bench for fifo_wr_arbiter with stream
//                requesters and a depth-8 FIFO occupancy model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  i_valid = '0;
    logic [31:0] i_data = '0;
    logic        i_full = 1'b0;
    logic [3:0]  o_ready;
    logic        o_wr_en;
    logic [7:0]  o_wr_data;
    logic [1:0]  o_wr_src;
    logic        o_busy;

    int checks = 0;
    int passed = 0;

    int  total[4];
    int  sent[4];
    bit  force_full;
    bit  drain;
    int  occ;
    int  max_occ;
    int  wr_while_full;
    int  cyc = 0;

    logic [7:0] log_data[$];
    logic [1:0] log_src[$];
    int         log_cyc[$];

    logic       obs_wr_en;
    logic       obs_busy;
    logic [3:0] obs_ready;
    logic [7:0] obs_data;
    logic [1:0] obs_src;

    fifo_wr_arbiter #(
        .NUM_REQ   (4),
        .WIDTH     (8),
        .MAX_BURST (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_valid   (i_valid),
        .i_data    (i_data),
        .o_ready   (o_ready),
        .o_wr_en   (o_wr_en),
        .o_wr_data (o_wr_data),
        .o_wr_src  (o_wr_src),
        .i_full    (i_full),
        .o_busy    (o_busy)
    );

    initial forever #5 clk = ~clk;

    // Requester k streams bytes k*64 + seq; data only advances after a handshake.
    task automatic drive();
        for (int k = 0; k < 4; k++) begin
            i_valid[k]       = (sent[k] < total[k]);
            i_data[k*8 +: 8] = 8'(k*64 + sent[k]);
        end
        i_full = force_full || (occ >= 8);
    endtask

    task automatic tick();
        bit rd;
        @(negedge clk);
        obs_wr_en = o_wr_en;
        obs_busy  = o_busy;
        obs_ready = o_ready;
        obs_data  = o_wr_data;
        obs_src   = o_wr_src;
        if (o_wr_en) begin
            log_data.push_back(o_wr_data);
            log_src.push_back(o_wr_src);
            log_cyc.push_back(cyc);
        end
        if (o_wr_en && i_full) wr_while_full++;
        for (int k = 0; k < 4; k++) begin
            if (o_ready[k] && i_valid[k]) sent[k]++;
        end
        rd  = drain && (occ > 0);
        occ = occ + (o_wr_en ? 1 : 0) - (rd ? 1 : 0);
        if (occ > max_occ) max_occ = occ;
        @(posedge clk);
        #1;
        cyc++;
        drive();
    endtask

    task automatic clear_log();
        log_data.delete();
        log_src.delete();
        log_cyc.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            total[k] = 0;
            sent[k]  = 0;
        end
        force_full    = 1'b0;
        drain         = 1'b1;
        occ           = 0;
        max_occ       = 0;
        wr_while_full = 0;
        clear_log();
        drive();
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic wait_beats(input int n, input int budget, output bit ok);
        int b;
        b = budget;
        while (log_data.size() < n && b > 0) begin
            tick();
            b--;
        end
        ok = (log_data.size() >= n);
    endtask

    task automatic test_reset();
        bit ok;
        do_reset();
        tick();
        checks++;
        if ({obs_busy, obs_wr_en, obs_ready, obs_src, obs_data} !== 16'h0)
            $display("FAIL reset_state busy=%b wr_en=%b ready=%b src=%0d data=%h required all zero",
                     obs_busy, obs_wr_en, obs_ready, obs_src, obs_data);
        else passed++;

        total[0] = 10;
        drive();
        wait_beats(2, 20, ok);
        checks++;
        if (!ok) $display("FAIL reset_preburst beats=%0d required=2", log_data.size());
        else passed++;

        // Abort the burst and present requester 2 while reset is held.
        rst      = 1'b1;
        total[0] = sent[0];
        total[2] = 10;
        drive();
        tick();
        checks++;
        if (obs_ready !== 4'b0000 || obs_wr_en !== 1'b0)
            $display("FAIL reset_cycle ready=%b wr_en=%b required ready=0000 wr_en=0", obs_ready, obs_wr_en);
        else passed++;

        rst = 1'b0;
        tick();
        checks++;
        if (obs_busy !== 1'b0 || obs_ready !== 4'b0000 || obs_wr_en !== 1'b0)
            $display("FAIL reset_after busy=%b ready=%b wr_en=%b required 0 0000 0", obs_busy, obs_ready, obs_wr_en);
        else passed++;

        tick();
        checks++;
        if (obs_wr_en !== 1'b1 || obs_src !== 2'd2 || obs_data !== 8'h80 || obs_ready !== 4'b0100)
            $display("FAIL reset_first_beat wr_en=%b src=%0d data=%h ready=%b required 1 2 80 0100",
                     obs_wr_en, obs_src, obs_data, obs_ready);
        else passed++;
    endtask

    task automatic test_single();
        int c0;
        bit ok;
        int exp_off[10];
        exp_off = '{1, 2, 3, 4, 6, 7, 8, 9, 11, 12};
        do_reset();
        total[1] = 10;
        drive();
        c0 = cyc;
        wait_beats(10, 40, ok);
        checks++;
        if (!ok) $display("FAIL single_timeout beats=%0d required=10", log_data.size());
        else passed++;
        if (ok) begin
            for (int i = 0; i < 10; i++) begin
                checks++;
                if (log_src[i] !== 2'd1 || log_data[i] !== 8'(64 + i))
                    $display("FAIL single_beat%0d src=%0d data=%h required src=1 data=%h",
                             i, log_src[i], log_data[i], 8'(64 + i));
                else passed++;
                checks++;
                if (log_cyc[i] - c0 !== exp_off[i])
                    $display("FAIL single_timing%0d cycle=%0d required=%0d", i, log_cyc[i] - c0, exp_off[i]);
                else passed++;
            end
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        int g;
        logic [1:0] exp_src;
        logic [7:0] exp_data;
        do_reset();
        for (int k = 0; k < 4; k++) total[k] = 12;
        drive();
        wait_beats(20, 80, ok);
        checks++;
        if (!ok) $display("FAIL rr_timeout beats=%0d required=20", log_data.size());
        else passed++;
        if (ok) begin
            for (int i = 0; i < 20; i++) begin
                g        = i / 4;
                exp_src  = 2'(g % 4);
                exp_data = 8'(int'(exp_src) * 64 + (g / 4) * 4 + i % 4);
                checks++;
                if (log_src[i] !== exp_src || log_data[i] !== exp_data)
                    $display("FAIL rr_beat%0d src=%0d data=%h required src=%0d data=%h",
                             i, log_src[i], log_data[i], exp_src, exp_data);
                else passed++;
            end
        end
    endtask

    task automatic test_wrap();
        bit ok;
        logic [1:0] exp_src[4];
        logic [7:0] exp_data[4];
        exp_src  = '{2'd0, 2'd0, 2'd1, 2'd1};
        exp_data = '{8'h00, 8'h01, 8'h40, 8'h41};
        do_reset();
        // A one-beat burst from requester 2 leaves the pointer at 3.
        total[2] = 1;
        drive();
        wait_beats(1, 10, ok);
        repeat (3) tick();
        checks++;
        if (!ok || obs_busy !== 1'b0)
            $display("FAIL wrap_setup beats=%0d busy=%b required beats=1 busy=0", log_data.size(), obs_busy);
        else passed++;
        clear_log();
        total[0] = 2;
        total[1] = 2;
        drive();
        wait_beats(4, 20, ok);
        checks++;
        if (!ok) $display("FAIL wrap_timeout beats=%0d required=4", log_data.size());
        else passed++;
        if (ok) begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (log_src[i] !== exp_src[i] || log_data[i] !== exp_data[i])
                    $display("FAIL wrap_beat%0d src=%0d data=%h required src=%0d data=%h",
                             i, log_src[i], log_data[i], exp_src[i], exp_data[i]);
                else passed++;
            end
        end
    endtask

    task automatic test_full();
        bit ok;
        int exp_seq[4];
        do_reset();
        drain    = 1'b0;
        total[0] = 4;
        drive();
        wait_beats(2, 20, ok);
        force_full = 1'b1;
        drive();
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (obs_wr_en !== 1'b0 || obs_ready !== 4'b0000 || obs_busy !== 1'b1)
                $display("FAIL full_hold%0d wr_en=%b ready=%b busy=%b required 0 0000 1",
                         i, obs_wr_en, obs_ready, obs_busy);
            else passed++;
        end
        force_full = 1'b0;
        drive();
        wait_beats(4, 20, ok);
        checks++;
        if (!ok || log_data[2] !== 8'h02 || log_data[3] !== 8'h03 || log_src[3] !== 2'd0)
            $display("FAIL full_resume beats=%0d required 4 beats ending 02,03 from src 0", log_data.size());
        else passed++;

        // Fill the modelled depth-8 FIFO; the arbiter must stall on its full flag.
        total[1] = 8;
        drive();
        repeat (12) tick();
        checks++;
        if (log_data.size() != 8 || occ != 8 || obs_busy !== 1'b1 || obs_wr_en !== 1'b0)
            $display("FAIL full_fifo beats=%0d occ=%0d busy=%b wr_en=%b required 8 8 1 0",
                     log_data.size(), occ, obs_busy, obs_wr_en);
        else passed++;

        drain = 1'b1;
        wait_beats(12, 60, ok);
        checks++;
        if (!ok || wr_while_full != 0 || max_occ > 8)
            $display("FAIL full_overflow beats=%0d writes_while_full=%0d max_occ=%0d required 12 0 <=8",
                     log_data.size(), wr_while_full, max_occ);
        else passed++;

        exp_seq = '{0, 0, 0, 0};
        for (int i = 0; i < log_data.size(); i++) begin
            checks++;
            if (log_data[i] !== 8'(int'(log_src[i]) * 64 + exp_seq[log_src[i]]))
                $display("FAIL full_order%0d src=%0d data=%h required %h",
                         i, log_src[i], log_data[i], 8'(int'(log_src[i]) * 64 + exp_seq[log_src[i]]));
            else passed++;
            exp_seq[log_src[i]]++;
        end
    endtask

    task automatic test_early_drop();
        bit ok;
        logic [1:0] exp_src[7];
        logic [7:0] exp_data[7];
        exp_src  = '{2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd2, 2'd2};
        exp_data = '{8'h80, 8'h81, 8'hC0, 8'hC1, 8'hC2, 8'h82, 8'h83};
        do_reset();
        total[2] = 2;
        total[3] = 3;
        drive();
        wait_beats(3, 30, ok);
        total[2] = 4;
        drive();
        wait_beats(7, 40, ok);
        checks++;
        if (!ok) $display("FAIL drop_timeout beats=%0d required=7", log_data.size());
        else passed++;
        if (ok) begin
            for (int i = 0; i < 7; i++) begin
                checks++;
                if (log_src[i] !== exp_src[i] || log_data[i] !== exp_data[i])
                    $display("FAIL drop_beat%0d src=%0d data=%h required src=%0d data=%h",
                             i, log_src[i], log_data[i], exp_src[i], exp_data[i]);
                else passed++;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached, checks=%0d passed=%0d", checks, passed);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_full();
        test_early_drop();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule : tb_fifo_wr_arbiter
`default_nettype wire
